// File: rtl/minhash_seed_scheduler.sv
// rtl/minhash_seed_scheduler.sv - shares one murmur hasher across NUM_HASHES seeds and streams per-seed minima
module minhash_seed_scheduler #(
    parameter int HASHER_DATA_BITS = 32,
    parameter int NUM_HASHES       = 8,
    parameter int CNT_BITS         = 16,
    localparam int IDX_BITS        = $clog2(NUM_HASHES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        cfg_we,
    input  logic [IDX_BITS-1:0]         cfg_addr,
    input  logic [HASHER_DATA_BITS-1:0] cfg_seed,
    input  logic                        kmer_valid,
    output logic                        kmer_ready,
    input  logic [HASHER_DATA_BITS-1:0] kmer_data,
    input  logic                        kmer_last,
    output logic [HASHER_DATA_BITS-1:0] hash_seed,
    output logic [HASHER_DATA_BITS-1:0] hash_kmer,
    input  logic [HASHER_DATA_BITS-1:0] hash_sig,
    output logic                        sig_valid,
    input  logic                        sig_ready,
    output logic [HASHER_DATA_BITS-1:0] sig_data,
    output logic [IDX_BITS-1:0]         sig_idx,
    output logic                        sig_last,
    output logic                        busy,
    output logic [CNT_BITS-1:0]         kmer_count
);

    typedef enum logic [1:0] {IDLE, HASH, OUT} state_t;

    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_HASHES - 1);

    state_t                        state_q, state_d;
    logic [IDX_BITS-1:0]           idx_q, idx_d;
    logic [HASHER_DATA_BITS-1:0]   kmer_reg_q, kmer_reg_d;
    logic                          last_reg_q, last_reg_d;
    logic [CNT_BITS-1:0]           kmer_count_q, kmer_count_d;
    logic [HASHER_DATA_BITS-1:0]   seed_q [NUM_HASHES];
    logic [HASHER_DATA_BITS-1:0]   seed_d [NUM_HASHES];
    logic [HASHER_DATA_BITS-1:0]   min_q  [NUM_HASHES];
    logic [HASHER_DATA_BITS-1:0]   min_d  [NUM_HASHES];

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        kmer_reg_d   = kmer_reg_q;
        last_reg_d   = last_reg_q;
        kmer_count_d = kmer_count_q;
        seed_d       = seed_q;
        min_d        = min_q;
        case (state_q)
            IDLE: begin
                // Seed write lands on the same edge as the accept, so HASH sees it.
                if (cfg_we) begin
                    seed_d[cfg_addr] = cfg_seed;
                end
                if (kmer_valid) begin
                    kmer_reg_d = kmer_data;
                    last_reg_d = kmer_last;
                    idx_d      = '0;
                    state_d    = HASH;
                    if (kmer_count_q != '1) begin
                        kmer_count_d = kmer_count_q + 1'b1;
                    end
                end
            end
            HASH: begin
                if (hash_sig < min_q[idx_q]) begin
                    min_d[idx_q] = hash_sig;
                end
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = last_reg_q ? OUT : IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            OUT: begin
                if (sig_ready) begin
                    if (idx_q == LAST_IDX) begin
                        for (int i = 0; i < NUM_HASHES; i++) begin
                            min_d[i] = '1;
                        end
                        kmer_count_d = '0;
                        idx_d        = '0;
                        state_d      = IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            kmer_reg_q   <= '0;
            last_reg_q   <= 1'b0;
            kmer_count_q <= '0;
            for (int i = 0; i < NUM_HASHES; i++) begin
                seed_q[i] <= HASHER_DATA_BITS'(i);
                min_q[i]  <= '1;
            end
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            kmer_reg_q   <= kmer_reg_d;
            last_reg_q   <= last_reg_d;
            kmer_count_q <= kmer_count_d;
            seed_q       <= seed_d;
            min_q        <= min_d;
        end
    end

    assign kmer_ready = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign hash_seed  = (state_q == HASH) ? seed_q[idx_q] : seed_q[0];
    assign hash_kmer  = kmer_reg_q;
    assign sig_valid  = (state_q == OUT);
    assign sig_data   = (state_q == OUT) ? min_q[idx_q] : '0;
    assign sig_idx    = (state_q == OUT) ? idx_q : '0;
    assign sig_last   = (state_q == OUT) && (idx_q == LAST_IDX);
    assign kmer_count = kmer_count_q;

endmodule
